dmem_port_arbiter: RTL

Two-port arbiter in front of the 1K x 16 data memory block RAM (synchronous read, one-cycle latency, write-first). It shares the single RAM port between the pipeline MEM stage (port A, high priority) and a loader/debug DMA requester (port B). It drives the RAM enable, write-enable, address and write-data, and returns read data tagged to the granted requester one cycle later. It includes a bounded-wait counter that keeps port B from starving.

---
 rtl/dmem_port_arbiter_if.sv | 71 +++++++
 rtl/dmem_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_if
//
// Bundles the two requester ports (A = pipeline MEM stage, B = loader/DMA)
// and the single-port data RAM bus that the arbiter drives.
//
// Signals
//   A_Req/B_Req         request, held until the matching grant
//   A_We/B_We           write (1) / read (0)
//   A_Addr/B_Addr       word address (bits above the RAM depth alias)
//   A_Wdata/B_Wdata     write data
//   A_Gnt/B_Gnt         access issued this cycle
//   A_Rvalid/B_Rvalid   read data valid (cycle after a granted read)
//   A_Rdata/B_Rdata     read data, zero when not valid
//   Mem_Enable          RAM enable
//   Mem_Write_Enab      RAM write enable
//   Mem_Add             RAM address
//   Mem_Data_in         RAM write data
//   Mem_Data_out        RAM read data, valid the cycle after the access
//   Oob_Err             pulse: a granted access carried non-zero upper bits
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus RAM)
// ----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int DSIZE = 16
);
  logic             A_Req;
  logic             A_We;
  logic [DSIZE-1:0] A_Addr;
  logic [DSIZE-1:0] A_Wdata;
  logic             A_Gnt;
  logic             A_Rvalid;
  logic [DSIZE-1:0] A_Rdata;

  logic             B_Req;
  logic             B_We;
  logic [DSIZE-1:0] B_Addr;
  logic [DSIZE-1:0] B_Wdata;
  logic             B_Gnt;
  logic             B_Rvalid;
  logic [DSIZE-1:0] B_Rdata;

  logic             Mem_Enable;
  logic             Mem_Write_Enab;
  logic [DSIZE-1:0] Mem_Add;
  logic [DSIZE-1:0] Mem_Data_in;
  logic [DSIZE-1:0] Mem_Data_out;
  logic             Oob_Err;

  modport slave (
    input  A_Req, A_We, A_Addr, A_Wdata,
    input  B_Req, B_We, B_Addr, B_Wdata,
    input  Mem_Data_out,
    output A_Gnt, A_Rvalid, A_Rdata,
    output B_Gnt, B_Rvalid, B_Rdata,
    output Mem_Enable, Mem_Write_Enab, Mem_Add, Mem_Data_in,
    output Oob_Err
  );

  modport master (
    output A_Req, A_We, A_Addr, A_Wdata,
    output B_Req, B_We, B_Addr, B_Wdata,
    output Mem_Data_out,
    input  A_Gnt, A_Rvalid, A_Rdata,
    input  B_Gnt, B_Rvalid, B_Rdata,
    input  Mem_Enable, Mem_Write_Enab, Mem_Add, Mem_Data_in,
    input  Oob_Err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single port of the 1K x 16 data RAM (synchronous read, one-cycle
// latency, write-first) between port A (pipeline MEM stage, high priority)
// and port B (loader/debug DMA). Arbitration is combinational, so a request
// is granted in the cycle it is presented; read data comes back one cycle
// later, tagged to whichever port issued the read.
//
// Ports
//   Clk_In  : clock, all state on the rising edge
//   Rst_In  : synchronous active-high reset; also masks grants and outputs
//   bus     : dmem_port_arbiter_if.slave (requester A/B + RAM bus)
//
// Parameters
//   DSIZE    : requester/memory data and address width
//   AWIDTH   : implemented RAM address bits
//   MAX_WAIT : consecutive A grants tolerated while B waits (1..15)
//
// Build option
//   DMEM_ARB_FAIRNESS_EN : when defined, a 4-bit wait counter forces a B
//   slot after MAX_WAIT A grants that B sat through. Undefined: strict
//   A priority, B can starve.
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int DSIZE    = 16,
  parameter int AWIDTH   = 10,
  parameter int MAX_WAIT = 4
) (
  input logic              Clk_In,
  input logic              Rst_In,
  dmem_port_arbiter_if.slave bus
);

  // Who owns the read data arriving from the RAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t rd_owner_reg, rd_owner_next;
  logic   oob_reg, oob_next;
  logic   a_gnt, b_gnt;
  logic   force_b;
  logic   a_hi, b_hi;

  // Elaboration-time guard on the wait bound.
  generate
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("dmem_port_arbiter: MAX_WAIT must be in 1..15");
    end
  endgenerate

  // Non-zero bits above the implemented depth mark an aliased access.
  generate
    if (AWIDTH < DSIZE) begin : g_oob
      assign a_hi = |bus.A_Addr[DSIZE-1:AWIDTH];
      assign b_hi = |bus.B_Addr[DSIZE-1:AWIDTH];
    end else begin : g_no_oob
      assign a_hi = 1'b0;
      assign b_hi = 1'b0;
    end
  endgenerate

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_reg, wait_cnt_next;

  // B has sat through MAX_WAIT A grants: give it this slot.
  assign force_b = bus.A_Req & bus.B_Req & (wait_cnt_reg == WAIT_MAX);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (b_gnt) begin
      wait_cnt_next = 4'd0;
    end else if (a_gnt && bus.B_Req && (wait_cnt_reg != WAIT_MAX)) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      wait_cnt_reg <= 4'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  // Grant decision: A first unless B is being forced; nothing in reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!Rst_In) begin
      if (bus.A_Req && !force_b) begin
        a_gnt = 1'b1;
      end else if (bus.B_Req) begin
        b_gnt = 1'b1;
      end
    end
  end

  // RAM bus mux and next-cycle tracking state.
  always_comb begin
    bus.Mem_Enable     = 1'b0;
    bus.Mem_Write_Enab = 1'b0;
    bus.Mem_Add        = '0;
    bus.Mem_Data_in    = '0;
    rd_owner_next      = OWN_NONE;
    oob_next           = 1'b0;
    if (a_gnt) begin
      bus.Mem_Enable     = 1'b1;
      bus.Mem_Write_Enab = bus.A_We;
      bus.Mem_Add        = bus.A_Addr;
      bus.Mem_Data_in    = bus.A_Wdata;
      rd_owner_next      = bus.A_We ? OWN_NONE : OWN_A;
      oob_next           = a_hi;
    end else if (b_gnt) begin
      bus.Mem_Enable     = 1'b1;
      bus.Mem_Write_Enab = bus.B_We;
      bus.Mem_Add        = bus.B_Addr;
      bus.Mem_Data_in    = bus.B_Wdata;
      rd_owner_next      = bus.B_We ? OWN_NONE : OWN_B;
      oob_next           = b_hi;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      rd_owner_reg <= OWN_NONE;
      oob_reg      <= 1'b0;
    end else begin
      rd_owner_reg <= rd_owner_next;
      oob_reg      <= oob_next;
    end
  end

  assign bus.A_Gnt = a_gnt;
  assign bus.B_Gnt = b_gnt;

  // Masking with Rst_In drops a read whose data would land in a reset cycle.
  assign bus.A_Rvalid = (rd_owner_reg == OWN_A) & ~Rst_In;
  assign bus.B_Rvalid = (rd_owner_reg == OWN_B) & ~Rst_In;
  assign bus.A_Rdata  = bus.A_Rvalid ? bus.Mem_Data_out : '0;
  assign bus.B_Rdata  = bus.B_Rvalid ? bus.Mem_Data_out : '0;
  assign bus.Oob_Err  = oob_reg & ~Rst_In;

endmodule
